// File: rtl/ntt_pkg.sv
// ntt_pkg: constants and state encoding shared by the NTT multiplier, reduction and butterfly stages
package ntt_pkg;
    localparam int COEF_W = 12;
    localparam logic [COEF_W-1:0] Q_KYBER = 12'd3329;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/mod_csub.sv
// mod_csub: conditional subtract, maps x in [0, 2q) to x mod q
module mod_csub
    import ntt_pkg::*;
#(
    parameter int W     = COEF_W + 2,
    parameter int OUT_W = COEF_W + 2
) (
    input  logic [W-1:0]     x_i,
    input  logic [W-1:0]     q_i,
    output logic [OUT_W-1:0] y_o
);
    logic [W-1:0] w_y;
    assign w_y = (x_i >= q_i) ? x_i - q_i : x_i;
    assign y_o = OUT_W'(w_y);
endmodule

// File: rtl/mod_mul_seq.sv
// mod_mul_seq: MSB-first interleaved shift-add-reduce modular multiplier, (a*b) mod q over WIDTH cycles
module mod_mul_seq
    import ntt_pkg::*;
#(
    parameter int WIDTH = COEF_W,
    parameter int CNT_W = 4
) (
    input  logic             clock_i,
    input  logic             nreset_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] q_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] product_o
);
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_q, r_acc, r_product;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH+1:0] w_t, w_s1, w_qx;
    logic [WIDTH-1:0] w_red;
    logic             w_accept, w_last;

    assign in_ready_o  = (r_state == IDLE);
    assign out_valid_o = (r_state == DONE);
    assign product_o   = r_product;
    assign w_accept    = in_valid_i & in_ready_o;
    assign w_last      = (r_count == '0);
    assign w_qx        = {2'b00, r_q};
    // t = 2*acc + (current multiplier bit ? b : 0); stays below 3q for in-range operands
    assign w_t         = {1'b0, r_acc, 1'b0} + (r_a[r_count] ? {2'b00, r_b} : '0);

    mod_csub #(.W(WIDTH + 2), .OUT_W(WIDTH + 2)) u_csub0 (
        .x_i (w_t),
        .q_i (w_qx),
        .y_o (w_s1)
    );

    mod_csub #(.W(WIDTH + 2), .OUT_W(WIDTH)) u_csub1 (
        .x_i (w_s1),
        .q_i (w_qx),
        .y_o (w_red)
    );

    // state register
    always_ff @(posedge clock_i or negedge nreset_i) begin
        if (!nreset_i) r_state <= IDLE;
        else           r_state <= w_next;
    end

    // next-state: accept in IDLE, WIDTH iterations in RUN, hold in DONE until consumed
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = in_valid_i  ? RUN  : IDLE;
            RUN:     w_next = w_last      ? DONE : RUN;
            DONE:    w_next = out_ready_i ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    // operand latch, accumulator iteration and result capture
    always_ff @(posedge clock_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_a       <= '0;
            r_b       <= '0;
            r_q       <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_a     <= a_i;
            r_b     <= b_i;
            r_q     <= q_i;
            r_acc   <= '0;
            r_count <= CNT_W'(WIDTH - 1);
        end else if (r_state == RUN) begin
            r_acc <= w_red;
            if (w_last) r_product <= w_red;
            else        r_count   <= r_count - CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_mod_mul_seq.sv
// tb_mod_mul_seq: scoreboard bench for mod_mul_seq against an arithmetic (a*b)%q model
module tb_mod_mul_seq;
    logic        clock_i = 1'b0;
    logic        nreset_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [11:0] a_i, b_i, q_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [11:0] product_o;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    mod_mul_seq dut (
        .clock_i     (clock_i),
        .nreset_i    (nreset_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .q_i         (q_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .product_o   (product_o)
    );

    always #5 clock_i = ~clock_i;

    function automatic int ref_mul(input int a, input int b, input int q);
        return (a * b) % q;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clock_i) begin
        int e;
        if (nreset_i && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("product", int'(product_o), e);
            end
        end
    end

    task automatic issue(input int a, input int b, input int q, input int e);
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (in_ready_o) begin
                ok = 1;
                break;
            end
            @(posedge clock_i); #1;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        a_i = 12'(a);
        b_i = 12'(b);
        q_i = 12'(q);
        in_valid_i = 1'b1;
        exp_q.push_back(e);
        @(posedge clock_i); #1;
        in_valid_i = 1'b0;
        a_i = 12'($urandom);
        b_i = 12'($urandom);
        q_i = 12'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clock_i);
        #1;
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic lat_run(input int a, input int b, input int q, input int e);
        issue(a, b, q, e);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clock_i); #1;
            chk("latency_valid", int'(out_valid_o), int'(k == 12));
            if (k < 12) chk("run_ready_low", int'(in_ready_o), 0);
        end
        drain();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b, q;
        bit ok;
        nreset_i = 1'b0;
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        a_i = '0;
        b_i = '0;
        q_i = '0;
        #1;
        chk("reset_in_ready", int'(in_ready_o), 1);
        chk("reset_out_valid", int'(out_valid_o), 0);
        chk("reset_product", int'(product_o), 0);
        repeat (3) @(posedge clock_i);
        #1;
        nreset_i = 1'b1;

        lat_run(17, 19, 3329, 323);
        lat_run(3328, 3328, 3329, 1);
        lat_run(1234, 2345, 3329, 829);
        lat_run(0, 3000, 3329, 0);
        lat_run(16, 16, 17, 1);

        out_ready_i = 1'b0;
        issue(1234, 2345, 3329, 829);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clock_i); #1;
            if (out_valid_o) begin
                ok = 1;
                break;
            end
        end
        chk("bp_valid_seen", int'(ok), 1);
        a_i = 12'd5;
        b_i = 12'd7;
        q_i = 12'd3329;
        in_valid_i = 1'b1;
        exp_q.push_back(35);
        for (int i = 0; i < 20; i++) begin
            @(posedge clock_i); #1;
            chk("bp_valid_hold", int'(out_valid_o), 1);
            chk("bp_product_hold", int'(product_o), 829);
            chk("bp_in_ready", int'(in_ready_o), 0);
        end
        out_ready_i = 1'b1;
        @(posedge clock_i); #1;
        chk("bp_idle_after_handoff", int'(in_ready_o), 1);
        @(posedge clock_i); #1;
        chk("bp_next_accepted", int'(in_ready_o), 0);
        in_valid_i = 1'b0;
        drain();

        issue(100, 200, 3329, ref_mul(100, 200, 3329));
        repeat (6) @(posedge clock_i);
        #1;
        nreset_i = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid_o), 0);
        chk("rst_product", int'(product_o), 0);
        chk("rst_in_ready", int'(in_ready_o), 1);
        exp_q.delete();
        @(posedge clock_i); #1;
        nreset_i = 1'b1;
        lat_run(2, 3, 3329, 6);

        issue(1000, 3000, 3329, ref_mul(1000, 3000, 3329));
        for (int i = 0; i < 13; i++) begin
            @(posedge clock_i); #1;
            a_i = 12'($urandom);
            b_i = 12'($urandom);
            q_i = 12'($urandom);
        end
        drain();

        for (int s = 0; s < 2; s++) begin
            q = (s == 0) ? 3329 : 17;
            for (int i = 0; i < 1500; i++) begin
                a = int'($urandom_range(0, q - 1));
                b = int'($urandom_range(0, q - 1));
                issue(a, b, q, ref_mul(a, b, q));
            end
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
